fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect/stall/flush
// handling and a sticky out-of-range fault that halts fetch until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd100,
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        pc_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_fault;
    logic [31:0] r_count;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_fault_nxt;
    logic [31:0] w_count_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Branch wins over jump; targets are word-aligned by clearing the low two bits
    assign w_target   = (branch_taken ? branch_target : jump_target) & ~32'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
            r_fault <= w_fault_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Priority per edge in RUN: redirect, fault, stall, normal fetch
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        w_fault_nxt = r_fault;
        w_count_nxt = r_count;

        case (r_state)
            S_RUN: begin
                if (branch_taken || jump) begin
                    w_pc_nxt    = w_target;
                    w_instr_nxt = 32'd0;
                    w_pc4_nxt   = 32'd0;
                    w_valid_nxt = 1'b0;
                end else if (r_pc > LAST_ADDR) begin
                    w_state_nxt = S_HALT;
                    w_fault_nxt = 1'b1;
                    w_instr_nxt = 32'd0;
                    w_pc4_nxt   = 32'd0;
                    w_valid_nxt = 1'b0;
                end else if (stall) begin
                    if (flush) begin
                        w_instr_nxt = 32'd0;
                        w_pc4_nxt   = 32'd0;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
                    w_pc_nxt = w_pc_plus4;
                    if (flush) begin
                        w_instr_nxt = 32'd0;
                        w_pc4_nxt   = 32'd0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_instr_nxt = instr_in;
                        w_pc4_nxt   = w_pc_plus4;
                        w_valid_nxt = 1'b1;
                        w_count_nxt = r_count + 32'd1;
                    end
                end
            end
            S_HALT: begin
                w_instr_nxt = 32'd0;
                w_pc4_nxt   = 32'd0;
                w_valid_nxt = 1'b0;
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign pc_out      = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;
    assign pc_fault    = r_fault;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        pc_fault;
    logic [31:0] fetch_count;

    int n_checks;
    int n_fail;

    fetch_stage #(
        .RESET_PC (32'd100),
        .MEM_BYTES(16384)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .instr_in     (instr_in),
        .pc_out       (pc_out),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .pc_fault     (pc_fault),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'd100: mem_word = 32'h4808_0000;
            32'd104: mem_word = 32'h4809_0004;
            32'd500: mem_word = 32'h2413_000F;
            default: mem_word = {16'hA5C3, addr[15:0]};
        endcase
    endfunction

    assign instr_in = mem_word(pc_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump          = 1'b0;
        jump_target   = 32'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    pc_out,      32'd100);
        check({tag, "_instr"}, if_id_instr, 32'd0);
        check({tag, "_pc4"},   if_id_pc4,   32'd0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        check({tag, "_fault"}, 32'(pc_fault),    32'd0);
        check({tag, "_count"}, fetch_count, 32'd0);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_instr"}, if_id_instr, 32'd0);
        check({tag, "_pc4"},   if_id_pc4,   32'd0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_reset_state("rst");

        // Reset release, first fetch from 100
        rst_n = 1'b1;
        tick();
        check("first_instr", if_id_instr, 32'h4808_0000);
        check("first_pc4",   if_id_pc4,   32'd104);
        check("first_pc",    pc_out,      32'd104);
        check("first_valid", 32'(if_id_valid), 32'd1);
        for (int i = 0; i < 7; i++) tick();
        check("run8_pc",    pc_out,      32'd132);
        check("run8_count", fetch_count, 32'd8);
        check("run8_instr", if_id_instr, {16'hA5C3, 16'd128});
        check("run8_pc4",   if_id_pc4,   32'd132);

        // Mid-cycle reset during a run
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        check("pre_stall_pc",    pc_out,      32'd108);
        check("pre_stall_instr", if_id_instr, 32'h4809_0004);

        // Stall held three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",    pc_out,      32'd108);
            check("stall_instr", if_id_instr, 32'h4809_0004);
            check("stall_pc4",   if_id_pc4,   32'd108);
            check("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        check("resume_instr", if_id_instr, {16'hA5C3, 16'd108});
        check("resume_pc4",   if_id_pc4,   32'd112);
        check("resume_pc",    pc_out,      32'd112);
        check("resume_count", fetch_count, 32'd3);

        // Stall with flush: PC holds, IF/ID bubbled
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check("stflush_pc", pc_out, 32'd112);
        check_bubble("stflush");

        // Flush alone: PC advances, IF/ID bubbled
        stall = 1'b0;
        tick();
        check("flush_pc", pc_out, 32'd116);
        check_bubble("flush");
        check("flush_count", fetch_count, 32'd3);
        flush = 1'b0;

        // Branch to unaligned 502 lands at 500
        branch_taken  = 1'b1;
        branch_target = 32'd502;
        tick();
        check("br_pc",    pc_out, 32'd500);
        check("br_valid", 32'(if_id_valid), 32'd0);
        idle_inputs();
        tick();
        check("br_instr", if_id_instr, 32'h2413_000F);
        check("br_pc4",   if_id_pc4,   32'd504);
        check("br_count", fetch_count, 32'd4);

        // Branch and jump with stall: branch wins and redirect overrides stall
        branch_taken  = 1'b1;
        branch_target = 32'd600;
        jump          = 1'b1;
        jump_target   = 32'd400;
        stall         = 1'b1;
        tick();
        check("both_pc", pc_out, 32'd600);
        check_bubble("both");
        idle_inputs();

        // Last legal word fetches normally
        jump        = 1'b1;
        jump_target = 32'd16380;
        tick();
        check("j16380_pc", pc_out, 32'd16380);
        idle_inputs();
        tick();
        check("last_pc",    pc_out,      32'd16384);
        check("last_valid", 32'(if_id_valid), 32'd1);
        check("last_instr", if_id_instr, {16'hA5C3, 16'd16380});
        check("last_fault", 32'(pc_fault), 32'd0);
        check("last_count", fetch_count, 32'd5);

        // Jump straight to 16384: no fault until the following fetch
        jump        = 1'b1;
        jump_target = 32'd16384;
        stall       = 1'b0;
        tick();
        check("j16384_pc",    pc_out, 32'd16384);
        check("j16384_fault", 32'(pc_fault), 32'd0);
        idle_inputs();
        tick();
        check("fault_flag",  32'(pc_fault), 32'd1);
        check("fault_pc",    pc_out,      32'd16384);
        check("fault_count", fetch_count, 32'd5);
        check_bubble("fault");

        // Halted: redirect ignored
        branch_taken  = 1'b1;
        branch_target = 32'd200;
        tick();
        tick();
        check("halt_pc",    pc_out, 32'd16384);
        check("halt_fault", 32'(pc_fault), 32'd1);
        check_bubble("halt");
        idle_inputs();

        // Reset leaves HALT
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("halt_rst");
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_instr", if_id_instr, 32'h4808_0000);
        check("post_rst_pc",    pc_out,      32'd104);
        check("post_rst_count", fetch_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
